text_fetch: RTL and testbench



---
 rtl/text_pkg.sv | 19 +
 rtl/text_ram.sv | 38 +++
 rtl/text_fetch.sv | 150 +++++++++++++++
 tb/tb_text_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared geometry, widths and constants for the text-mode character fetch stage.
package text_pkg;

    localparam int CELL_W         = 8;
    localparam int CELL_H         = 12;
    localparam int GLYPH_BITS     = 96;
    localparam int CHAR_BITS      = 7;
    localparam int CELL_ADDR_BITS = 12;

    // Pixel-in-cell positions at which each fetch stage fires.
    localparam logic [2:0] PH_E0 = 3'd4;
    localparam logic [2:0] PH_E1 = 3'd5;
    localparam logic [2:0] PH_E2 = 3'd6;
    localparam logic [2:0] PH_E3 = 3'd7;

    // The underline cursor inverts the bottom two glyph rows.
    localparam logic [GLYPH_BITS-1:0] CURSOR_MASK = {80'h0, 16'hFFFF};

endpackage

// File: rtl/text_ram.sv
// Text buffer: simple dual-port RAM with a host write port and a registered read-first fetch port.
// Stored characters survive reset; only the read register is cleared.
module text_ram
    import text_pkg::*;
#(
    parameter int DEPTH = 1 << CELL_ADDR_BITS
) (
    input  logic                      clock25,
    input  logic                      reset,
    input  logic                      i_wrEn,
    input  logic [CELL_ADDR_BITS-1:0] i_wrAddr,
    input  logic [CHAR_BITS-1:0]      i_wrData,
    input  logic                      i_rdEn,
    input  logic [CELL_ADDR_BITS-1:0] i_rdAddr,
    output logic [CHAR_BITS-1:0]      o_rdData
);

    logic [CHAR_BITS-1:0] r_mem [DEPTH];
    logic [CHAR_BITS-1:0] r_rdData;

    always_ff @(posedge clock25) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // A same-cycle write to the read address is not visible until the next read.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/text_fetch.sv
// Text-mode character fetch: walks the text buffer one cell ahead of the raster, drives the
// font ROM and hands pixel_gen a 96-bit glyph per cell, with a blinking underline cursor.
module text_fetch
    import text_pkg::*;
#(
    parameter int H_VISIBLE    = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_TOTAL      = 525,
    parameter int COLS         = 80,
    parameter int ROWS         = 40,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      clock25,
    input  logic                      reset,
    input  logic [9:0]                HorizontalCounter,
    input  logic [9:0]                VerticalCounter,
    input  logic                      wr_en,
    input  logic [CELL_ADDR_BITS-1:0] wr_addr,
    input  logic [CHAR_BITS-1:0]      wr_data,
    input  logic                      cursor_en,
    input  logic [6:0]                cursor_col,
    input  logic [5:0]                cursor_row,
    output logic [CHAR_BITS-1:0]      font_addr,
    input  logic [GLYPH_BITS-1:0]     font_data,
    output logic [GLYPH_BITS-1:0]     glyph_data,
    output logic                      cell_valid
);

    localparam int VIS_COLS = (COLS < H_VISIBLE / CELL_W) ? COLS : H_VISIBLE / CELL_W;
    localparam int BCW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [10:0]               w_hNext;
    logic [9:0]                w_vNext;
    logic [6:0]                w_col;
    logic [6:0]                w_row;
    logic                      w_inRange;
    logic                      w_vis;
    logic                      w_curHit;
    logic [CELL_ADDR_BITS-1:0] w_textAddr;
    logic                      w_e0;
    logic                      w_e1;
    logic                      w_e2;
    logic                      w_e3;
    logic                      w_tick;
    logic                      w_wrOk;
    logic [GLYPH_BITS-1:0]     w_cursorMask;
    logic [CHAR_BITS-1:0]      w_charQ;

    logic [CELL_ADDR_BITS-1:0] r_textAddr;
    logic                      r_visP0;
    logic                      r_visP1;
    logic                      r_visP2;
    logic                      r_curP0;
    logic                      r_curP1;
    logic                      r_curP2;
    logic [GLYPH_BITS-1:0]     r_glyph;
    logic                      r_cellValid;
    logic [BCW-1:0]            r_blinkCnt;
    logic                      r_blinkPhase;

    // Look half a cell ahead; near the end of a line this lands on column 0 of the next line.
    always_comb begin
        w_inRange = (HorizontalCounter < 10'(H_TOTAL)) && (VerticalCounter < 10'(V_TOTAL));
        w_hNext   = {1'b0, HorizontalCounter} + 11'(CELL_W / 2);
        w_col     = '0;
        w_vNext   = VerticalCounter;
        if (w_hNext >= 11'(H_TOTAL)) begin
            w_vNext = (VerticalCounter == 10'(V_TOTAL - 1)) ? '0 : VerticalCounter + 10'd1;
        end else begin
            w_col = 7'(w_hNext / 11'(CELL_W));
        end
        w_row      = 7'(w_vNext / 10'(CELL_H));
        w_vis      = w_inRange && (w_col < 7'(VIS_COLS)) && (w_vNext < 10'(V_VISIBLE));
        w_curHit   = cursor_en && w_vis && (w_col == cursor_col) && (w_row == {1'b0, cursor_row});
        w_textAddr = CELL_ADDR_BITS'(w_row) * CELL_ADDR_BITS'(COLS) + CELL_ADDR_BITS'(w_col);
    end

    assign w_e0   = (HorizontalCounter[2:0] == PH_E0);
    assign w_e1   = (HorizontalCounter[2:0] == PH_E1);
    assign w_e2   = (HorizontalCounter[2:0] == PH_E2);
    assign w_e3   = (HorizontalCounter[2:0] == PH_E3);
    assign w_tick = (HorizontalCounter == '0) && (VerticalCounter == '0);
    assign w_wrOk = wr_en && (wr_addr < CELL_ADDR_BITS'(COLS * ROWS));

    assign w_cursorMask = (r_curP2 && r_blinkPhase) ? CURSOR_MASK : '0;

    text_ram u_textRam (
        .clock25  (clock25),
        .reset    (reset),
        .i_wrEn   (w_wrOk),
        .i_wrAddr (wr_addr),
        .i_wrData (wr_data),
        .i_rdEn   (w_e1),
        .i_rdAddr (r_textAddr),
        .o_rdData (w_charQ)
    );

    // Visibility and cursor flags travel with the cell through the ROM latency.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            r_textAddr  <= '0;
            r_visP0     <= 1'b0;
            r_visP1     <= 1'b0;
            r_visP2     <= 1'b0;
            r_curP0     <= 1'b0;
            r_curP1     <= 1'b0;
            r_curP2     <= 1'b0;
            r_glyph     <= '0;
            r_cellValid <= 1'b0;
        end else begin
            if (w_e0) begin
                r_textAddr <= w_textAddr;
                r_visP0    <= w_vis;
                r_curP0    <= w_curHit;
            end
            if (w_e1) begin
                r_visP1 <= r_visP0;
                r_curP1 <= r_curP0;
            end
            if (w_e2) begin
                r_visP2 <= r_visP1;
                r_curP2 <= r_curP1;
            end
            if (w_e3) begin
                r_glyph     <= r_visP2 ? (font_data ^ w_cursorMask) : '0;
                r_cellValid <= r_visP2;
            end
        end
    end

    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (w_tick) begin
            if (r_blinkCnt == BCW'(BLINK_FRAMES - 1)) begin
                r_blinkCnt   <= '0;
                r_blinkPhase <= ~r_blinkPhase;
            end else begin
                r_blinkCnt <= r_blinkCnt + 1'b1;
            end
        end
    end

    assign font_addr  = w_charQ;
    assign glyph_data = r_glyph;
    assign cell_valid = r_cellValid;

endmodule

// File: tb/tb_text_fetch.sv
// Scoreboard bench for text_fetch: stimulus drives raster counters cell by cell and queues
// expected font addresses and glyphs; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_text_fetch;

    localparam int BF = 2;

    logic        clock25 = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  hCnt = 10'd1;
    logic [9:0]  vCnt = 10'd1;
    logic        wrEn = 1'b0;
    logic [11:0] wrAddr = '0;
    logic [6:0]  wrData = '0;
    logic        cursorEn = 1'b0;
    logic [6:0]  cursorCol = '0;
    logic [5:0]  cursorRow = '0;
    logic [6:0]  fontAddr;
    logic [95:0] fontData = '0;
    logic [95:0] glyphData;
    logic        cellValid;

    int total = 0;
    int bad = 0;
    int fontMode = 0;
    int textMirror [3200];
    int blinkCnt = 0;
    bit blinkPhase = 1'b0;

    logic [96:0] glyphQ [$];
    int          glyphTag [$];
    int          charQ [$];
    int          charTag [$];

    logic [9:0]  edgeH = '0;
    logic        edgeRst = 1'b0;
    logic [96:0] heldExp = '0;
    logic [96:0] popGlyph;
    int          popTag;
    int          popChar;

    text_fetch #(.BLINK_FRAMES(BF)) dut (
        .clock25           (clock25),
        .reset             (reset),
        .HorizontalCounter (hCnt),
        .VerticalCounter   (vCnt),
        .wr_en             (wrEn),
        .wr_addr           (wrAddr),
        .wr_data           (wrData),
        .cursor_en         (cursorEn),
        .cursor_col        (cursorCol),
        .cursor_row        (cursorRow),
        .font_addr         (fontAddr),
        .font_data         (fontData),
        .glyph_data        (glyphData),
        .cell_valid        (cellValid)
    );

    always #5 clock25 = ~clock25;

    function automatic logic [95:0] fontFunc(input logic [6:0] code);
        case (fontMode)
            0:       return {12{8'hA5}};
            1:       return {12{1'b1, code}};
            default: return '0;
        endcase
    endfunction

    // Registered font ROM with one cycle of latency.
    always @(posedge clock25) fontData <= fontFunc(fontAddr);

    always @(posedge clock25) begin
        edgeH   <= hCnt;
        edgeRst <= reset;
    end

    task automatic checkOutput(input string name, input int tag, input logic [103:0] act,
                               input logic [103:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s tag=%0d got=%h want=%h", name, tag, act, exp);
        end
    endtask

    // Monitor: E1 edges present a font address, E3 edges present a new glyph, others must hold.
    always @(negedge clock25) begin
        if (reset || edgeRst) begin
            heldExp = '0;
            checkOutput("resetState", 0, {fontAddr, cellValid, glyphData}, '0);
        end else if (edgeH[2:0] == 3'd7) begin
            if (glyphQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL glyphQueue got=empty want=entry at H=%0d", edgeH);
            end else begin
                popGlyph = glyphQ.pop_front();
                popTag   = glyphTag.pop_front();
                heldExp  = popGlyph;
                checkOutput("glyphE3", popTag, {7'b0, cellValid, glyphData}, {7'b0, popGlyph});
            end
        end else begin
            if (edgeH[2:0] == 3'd5) begin
                if (charQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL charQueue got=empty want=entry at H=%0d", edgeH);
                end else begin
                    popChar = charQ.pop_front();
                    popTag  = charTag.pop_front();
                    if (popChar >= 0)
                        checkOutput("fontAddr", popTag, {97'b0, fontAddr}, {97'b0, 7'(popChar)});
                end
            end
            checkOutput("glyphHeld", 0, {7'b0, cellValid, glyphData}, {7'b0, heldExp});
        end
    end

    task automatic driveHV(input int h, input int v);
        hCnt = 10'(h);
        vCnt = 10'(v);
        @(posedge clock25);
        if (h == 0 && v == 0 && !reset) begin
            if (blinkCnt == BF - 1) begin
                blinkCnt   = 0;
                blinkPhase = !blinkPhase;
            end else begin
                blinkCnt++;
            end
        end
        #1;
    endtask

    task automatic hostWrite(input int a, input int d);
        wrEn   = 1'b1;
        wrAddr = 12'(a);
        wrData = 7'(d);
        driveHV(1, 1);
        wrEn = 1'b0;
        if (a < 3200) textMirror[a] = d;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        driveHV(1, 1);
        driveHV(1, 1);
        reset      = 1'b0;
        blinkCnt   = 0;
        blinkPhase = 1'b0;
    endtask

    // One cell fetch: H runs hs..hs+7 (hs = 4 mod 8), covering E0..E3 and the first half of the cell.
    task automatic applyStimulus(input int v, input int hs, input bit doWr, input int wa, input int wd);
        int hn, vn, col, row, code, h, vv;
        bit vis, cur;
        logic [95:0] g;
        hn = hs + 4;
        if (hn >= 800) begin
            col = 0;
            vn  = (v + 1) % 525;
        end else begin
            col = hn / 8;
            vn  = v;
        end
        row  = vn / 12;
        vis  = (col < 80) && (vn < 480);
        cur  = cursorEn && vis && (col == int'(cursorCol)) && (row == int'(cursorRow));
        code = vis ? textMirror[row * 80 + col] : -1;
        g    = '0;
        if (vis) begin
            g = fontFunc(7'(code));
            if (cur && blinkPhase) g = g ^ {80'h0, 16'hFFFF};
        end
        glyphQ.push_back({vis, g});
        glyphTag.push_back(row * 100 + col);
        charQ.push_back(code);
        charTag.push_back(row * 100 + col);
        for (int i = 0; i < 8; i++) begin
            h  = hs + i;
            vv = v;
            if (h >= 800) begin
                h  = h - 800;
                vv = (v + 1) % 525;
            end
            if (doWr && i == 1) begin
                wrEn   = 1'b1;
                wrAddr = 12'(wa);
                wrData = 7'(wd);
            end
            driveHV(h, vv);
            wrEn = 1'b0;
        end
        if (doWr && wa < 3200) textMirror[wa] = wd;
    endtask

    task automatic fetchCell(input int a);
        int row, col;
        row = a / 80;
        col = a % 80;
        if (col == 0) applyStimulus((row == 0) ? 524 : row * 12 - 1, 796, 1'b0, 0, 0);
        else          applyStimulus(row * 12 + 5, col * 8 - 4, 1'b0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3200; i++) textMirror[i] = -1;
        #1;
        reset = 1'b1;
        driveHV(1, 1);
        driveHV(1, 1);
        driveHV(1, 1);
        reset = 1'b0;
        driveHV(1, 1);

        $display("[TB] line-0 prefetch from the end of the previous frame");
        fontMode = 0;
        hostWrite(0, 70);
        hostWrite(1, 5);
        applyStimulus(524, 796, 1'b0, 0, 0);
        applyStimulus(0, 4, 1'b0, 0, 0);

        $display("[TB] last visible cell and right border");
        fontMode = 1;
        hostWrite(3199, 65);
        hostWrite(3198, 12);
        applyStimulus(479, 620, 1'b0, 0, 0);
        applyStimulus(479, 628, 1'b0, 0, 0);
        applyStimulus(479, 636, 1'b0, 0, 0);
        applyStimulus(479, 644, 1'b0, 0, 0);

        $display("[TB] cursor blink");
        applyReset();
        fontMode  = 2;
        cursorEn  = 1'b1;
        cursorCol = 7'd3;
        cursorRow = 6'd2;
        hostWrite(162, 1);
        hostWrite(163, 2);
        hostWrite(164, 3);
        hostWrite(83, 4);
        for (int f = 1; f <= 8; f++) begin
            driveHV(0, 0);
            applyStimulus(24, 12, 1'b0, 0, 0);
            applyStimulus(24, 20, 1'b0, 0, 0);
            applyStimulus(24, 28, 1'b0, 0, 0);
            applyStimulus(12, 20, 1'b0, 0, 0);
        end
        cursorEn = 1'b0;

        $display("[TB] write colliding with fetch read");
        fontMode = 1;
        hostWrite(81, 20);
        applyStimulus(12, 4, 1'b1, 81, 66);
        driveHV(0, 0);
        applyStimulus(12, 4, 1'b0, 0, 0);

        $display("[TB] reset mid-line");
        hostWrite(677, 40);
        hostWrite(678, 41);
        hostWrite(679, 42);
        applyStimulus(100, 292, 1'b0, 0, 0);
        reset = 1'b1;
        driveHV(300, 100);
        driveHV(301, 100);
        reset      = 1'b0;
        blinkCnt   = 0;
        blinkPhase = 1'b0;
        glyphQ.push_back('0);
        glyphTag.push_back(838);
        for (int h = 302; h < 308; h++) driveHV(h, 100);
        applyStimulus(100, 308, 1'b0, 0, 0);

        $display("[TB] out-of-range write");
        hostWrite(1452, 33);
        hostWrite(428, 34);
        hostWrite(0, 35);
        hostWrite(3199, 36);
        hostWrite(300, 37);
        hostWrite(3500, 99);
        fetchCell(1452);
        fetchCell(428);
        fetchCell(0);
        fetchCell(3199);
        fetchCell(300);

        driveHV(1, 1);
        driveHV(1, 1);
        total++;
        if (glyphQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL glyphLeftover got=%0d want=0", glyphQ.size());
        end
        total++;
        if (charQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL charLeftover got=%0d want=0", charQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
